// File: rtl/bli201v32itl_fetch_queue_pkg.sv
// Shared core constants for the fetch queue: datapath width, the NOP
// instruction shown to decode when empty, and the width of one queue entry.
package bli201v32itl_defines;
  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;  // addi x0,x0,0
  localparam int          ENTRY_W  = 2 * XLEN;      // {pc, inst}
endpackage

// File: rtl/bli201v32itl_fq_storage.sv
// Fetch-queue storage: DEPTH rows of W bits, one write port, async read port,
// synchronous active-low clear. Each row is a clearable, clock-enabled register.
module dff_reg_rce #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_b)  q <= '0;
    else if (ce) q <= d;
  end
endmodule

module bli201v32itl_fq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] rows [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    dff_reg_rce #(.W(W)) u_row (
      .clk   (clk),
      .rst_b (rst),
      .ce    (we && (waddr == AW'(i))),
      .d     (wdata),
      .q     (rows[i])
    );
  end

  assign rdata = rows[raddr];
endmodule

// File: rtl/bli201v32itl_fetch_queue.sv
// IFU-to-decode decoupling queue. Holds {pc, inst} pairs, halts fetch when
// full, and discards every entry on a redirect flush.
module bli201v32itl_fetch_queue
  import bli201v32itl_defines::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fq_i_push,
  input  logic [XLEN-1:0] fq_i_pc,
  input  logic [XLEN-1:0] fq_i_inst,
  output logic            fq_o_halt,
  input  logic            fq_i_flush,
  output logic            fq_o_valid,
  output logic [XLEN-1:0] fq_o_pc,
  output logic [XLEN-1:0] fq_o_inst,
  input  logic            fq_i_ready,
  output logic [CW-1:0]   fq_o_count
);
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push_acc, pop_acc;
  logic [ENTRY_W-1:0] head;

  assign fq_o_valid = (count != '0);
  assign fq_o_halt  = (count == CW'(DEPTH));
  assign fq_o_count = count;

  // Halt is registered, so a full queue refuses a push even while popping.
  assign push_acc = fq_i_push & ~fq_o_halt & ~fq_i_flush;
  assign pop_acc  = fq_o_valid & fq_i_ready & ~fq_i_flush;

  always_ff @(posedge clk) begin
    if (!rst || fq_i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_acc) - CW'(pop_acc);
    end
  end

  bli201v32itl_fq_storage #(.DEPTH(DEPTH), .W(ENTRY_W)) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata ({fq_i_pc, fq_i_inst}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign fq_o_pc   = fq_o_valid ? head[ENTRY_W-1:XLEN] : '0;
  assign fq_o_inst = fq_o_valid ? head[XLEN-1:0]       : NOP_INST;
endmodule
